vga_sync_rx: RTL
================

# vga_sync_rx

Video timing receiver and pixel capture for the pixel-clock domain. It accepts an HS/VS/DE/RGB444 stream of the kind our VGA timing generator drives. It measures line period, HS width, frame height and VS width, then locks once two consecutive frames match. While locked it emits pixel coordinates and a valid strobe, so a framebuffer writer or checker can consume incoming video.

## Interface
- `TIMEOUT`, default 2047: number of pixel clocks without an HS falling edge before the block drops to SEARCH. Maximum value is 2047.
- `vga_clk`  in  1  pixel clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `vga_hs`  in  1  horizontal sync, active-low pulse.
- `vga_vs`  in  1  vertical sync, active-low pulse.
- `vga_de`  in  1  data enable (hsync_de & vsync_de).
- `rgb_in`  in  12  pixel {R[11:8],G[7:4],B[3:0]}.
- `line_period`  out  11  measured clocks per line.
- `hs_width`  out  11  measured HS low width in clocks.
- `frame_lines`  out  10  measured lines per frame.
- `vs_width`  out  10  measured VS low width in lines.
- `locked`  out  1  timing stable.
- `err`  out  1  one-cycle pulse on loss of lock.
- `frame_start`  out  1  one-cycle pulse on every VS fall while locked.
- `pix_valid`  out  1  captured pixel valid.
- `pix_x`  out  11  pixel column.
- `pix_y`  out  10  pixel row.
- `pix_rgb`  out  12  captured pixel.

## Operation
- **Input stage.** All inputs are registered once. A second register holds the previous HS/VS sample. A fall is sample 1→0 and a rise is sample 0→1; all measurement uses the registered samples.
- **hcnt (11b).** Set to 1 on an HS fall. Otherwise it increments and saturates at 2047.
  - On an HS fall, the pre-reload `hcnt` value is the period of the line just ended.
  - On an HS rise, `hcnt` is the HS width of the current line.
- **lcnt (10b, saturating).** On a VS fall, set to 1 if an HS fall occurs in the same cycle, else 0. Otherwise it increments on each HS fall. On a VS fall, the pre-reload `lcnt` value is the frame height.
- **vcnt.** Counts HS falls in cycles where the VS sample is low. Captured on a VS rise.
- **FSM states:** SEARCH, MEASURE, VERIFY, LOCKED.
- **SEARCH → MEASURE** on the first VS fall. Clears all candidate registers.
- **MEASURE → VERIFY** on the next VS fall. Copies the last line period, HS width, frame height and VS width into the reference registers. Sets `line_err` if any line in the frame differed from the first line's period.
- **VERIFY → LOCKED** on the next VS fall, when the new frame matches the reference on all four values and has no line-period mismatch. On a mismatch it reloads the reference and stays in VERIFY.
- **LOCKED → MEASURE** on the first HS fall whose period differs from the reference, or on a VS fall whose frame height or VS width differs. The exit pulses `err` for one cycle.
- **Any state → SEARCH** when `hcnt` reaches `TIMEOUT`. If the exit is from LOCKED, `err` also pulses.
- **Boundary values.**
  - A saturated `lcnt` counts as a mismatch.
  - An HS fall and a VS fall in the same cycle: the line check is applied first, then the frame check.
  - `err` and the lock decision never assert in the same cycle; loss wins.
- **Measurement outputs** show the reference registers. They are 0 until the block first reaches VERIFY.

## Timing
- **Reset values:** all outputs are 0, the FSM is in SEARCH, and all counters and references are 0.
- **Reset mid-frame:** the block discards all state. Relock needs three VS falls after reset release.
- **`locked`** asserts in the cycle after the third VS fall is detected (input register + edge register + FSM register). It deasserts in the same cycle `err` pulses.
- **`frame_start`** is registered and asserts 2 cycles after the VS input falls.

## Configuration
- **`VGA_RX_PIXEL_EN` defined:** the pixel capture path is built.
  - `pix_valid` = registered DE & `locked`.
  - `pix_x` starts at 0 on the first DE cycle of a line and increments per DE cycle.
  - `pix_y` resets to 0 on a VS fall and increments on each DE 1→0 transition.
  - `pix_rgb` carries `rgb_in` with the same alignment. Latency from the input is 2 clocks.
- **Undefined:** `pix_valid`, `pix_x`, `pix_y` and `pix_rgb` are tied to 0, and no capture registers are built.

## Test plan
- **640x480 lock:** 800-clock lines, HS low 96 clocks, 525 lines per frame, VS falling with HS and low 1600 clocks. Expect `line_period`=800, `hs_width`=96, `frame_lines`=525, `vs_width`=2. Expect `locked`=1 one cycle after the 3rd VS fall detection and `frame_start` every frame after.
- **Pixel path (macro defined):** 640x480 active with `rgb_in` = x[11:0]. Expect the first `pix_valid` at `pix_x`=0, `pix_y`=0, `pix_rgb`=0. Expect the last at 639/479 with `pix_rgb`=0x27F. Expect exactly 307200 valid cycles per frame.
- **Line glitch:** one 801-clock line while locked. Expect a one-cycle `err` at that HS fall and `locked`=0. Relock follows after 2 further clean frames.
- **Timeout:** HS held high while locked. Expect `err` and SEARCH when `hcnt` reaches 2047. Outputs retain their last measurements until the next VERIFY.
- **Reset mid-frame:** `rst` for 1 cycle at line 200 of a locked stream. Expect all outputs at 0 the next cycle, and `locked` again only after 3 VS falls.
- **Macro undefined:** the 640x480 stream still locks with identical measurements, while `pix_valid` stays 0 throughout.

Source files
------------

// File: rtl/vga_sync_rx.sv
// Video timing receiver: measures line/frame timing, locks after two matching frames.
// Define VGA_RX_PIXEL_EN to build the pixel capture path (pix_* outputs tie to 0 otherwise).
module vga_sync_rx #(
    parameter int unsigned TIMEOUT = 2047
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_de,
    input  logic [11:0] rgb_in,
    output logic [10:0] line_period,
    output logic [10:0] hs_width,
    output logic [9:0]  frame_lines,
    output logic [9:0]  vs_width,
    output logic        locked,
    output logic        err,
    output logic        frame_start,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb
);
    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
    localparam logic [10:0] TO = TIMEOUT[10:0];

    logic        hs_q, vs_q, hs_p_q, vs_p_q;
    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  lcnt_q, lcnt_d, vcnt_q, vcnt_d;
    logic [10:0] cand_period_q, cand_hsw_q, first_period_q;
    logic [9:0]  cand_vsw_q;
    logic        have_first_q, line_err_q;
    logic [10:0] cur_period, cur_hsw;
    logic [9:0]  cur_vsw;
    logic        lcnt_sat, line_err_now, timeout, start_measure;
    logic        line_bad, frame_bad, frame_match;
    state_t      state_q;
    logic [10:0] ref_period_q, ref_hsw_q;
    logic [9:0]  ref_lines_q, ref_vsw_q;
    logic        ref_line_err_q, locked_q, err_q, fs_q;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            hs_p_q <= 1'b0;
            vs_p_q <= 1'b0;
        end else begin
            hs_q   <= vga_hs;
            vs_q   <= vga_vs;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
        end
    end

    always_comb begin
        hs_fall  = hs_p_q & ~hs_q;
        hs_rise  = ~hs_p_q & hs_q;
        vs_fall  = vs_p_q & ~vs_q;
        vs_rise  = ~vs_p_q & vs_q;
        lcnt_sat = &lcnt_q;

        hcnt_d = hcnt_q;
        if (hs_fall)
            hcnt_d = 11'd1;
        else if (!(&hcnt_q))
            hcnt_d = hcnt_q + 11'd1;

        lcnt_d = lcnt_q;
        if (vs_fall)
            lcnt_d = {9'd0, hs_fall};
        else if (hs_fall && !lcnt_sat)
            lcnt_d = lcnt_q + 10'd1;

        vcnt_d = vcnt_q;
        if (vs_fall)
            vcnt_d = {9'd0, hs_fall};
        else if (hs_fall && !vs_q && !(&vcnt_q))
            vcnt_d = vcnt_q + 10'd1;

        // Values as they stand including any edge seen this cycle.
        cur_period   = hs_fall ? hcnt_q : cand_period_q;
        cur_hsw      = hs_rise ? hcnt_q : cand_hsw_q;
        cur_vsw      = vs_rise ? vcnt_q : cand_vsw_q;
        line_err_now = line_err_q | (hs_fall & have_first_q & (hcnt_q != first_period_q));

        timeout       = (hcnt_q >= TO);
        start_measure = (state_q == SEARCH) && vs_fall && !timeout;
        line_bad      = hs_fall && (hcnt_q != ref_period_q);
        frame_bad     = vs_fall && (lcnt_sat || (lcnt_q != ref_lines_q) || (cur_vsw != ref_vsw_q));
        frame_match   = vs_fall && !lcnt_sat && (lcnt_q == ref_lines_q) &&
                        (cur_period == ref_period_q) && (cur_hsw == ref_hsw_q) &&
                        (cur_vsw == ref_vsw_q) && !line_err_now && !ref_line_err_q;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hcnt_q         <= '0;
            lcnt_q         <= '0;
            vcnt_q         <= '0;
            cand_period_q  <= '0;
            cand_hsw_q     <= '0;
            cand_vsw_q     <= '0;
            first_period_q <= '0;
            have_first_q   <= 1'b0;
            line_err_q     <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            lcnt_q <= lcnt_d;
            vcnt_q <= vcnt_d;
            if (start_measure) begin
                cand_period_q  <= '0;
                cand_hsw_q     <= '0;
                cand_vsw_q     <= '0;
                first_period_q <= '0;
                have_first_q   <= 1'b0;
                line_err_q     <= 1'b0;
            end else begin
                if (hs_fall) begin
                    cand_period_q <= hcnt_q;
                    line_err_q    <= line_err_now;
                    if (!have_first_q) begin
                        first_period_q <= hcnt_q;
                        have_first_q   <= 1'b1;
                    end
                end
                if (hs_rise)
                    cand_hsw_q <= hcnt_q;
                if (vs_rise)
                    cand_vsw_q <= vcnt_q;
                // The line ending at a VS fall belongs to the old frame; start fresh after it.
                if (vs_fall) begin
                    have_first_q <= 1'b0;
                    line_err_q   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q        <= SEARCH;
            ref_period_q   <= '0;
            ref_hsw_q      <= '0;
            ref_lines_q    <= '0;
            ref_vsw_q      <= '0;
            ref_line_err_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            fs_q           <= 1'b0;
        end else begin
            err_q <= 1'b0;
            fs_q  <= 1'b0;
            if (timeout) begin
                state_q  <= SEARCH;
                err_q    <= (state_q == LOCKED);
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    SEARCH: if (vs_fall) state_q <= MEASURE;
                    MEASURE, VERIFY: begin
                        if (vs_fall) begin
                            if (state_q == VERIFY && frame_match) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q        <= VERIFY;
                                ref_period_q   <= cur_period;
                                ref_hsw_q      <= cur_hsw;
                                ref_lines_q    <= lcnt_q;
                                ref_vsw_q      <= cur_vsw;
                                ref_line_err_q <= line_err_now;
                            end
                        end
                    end
                    LOCKED: begin
                        if (line_bad || frame_bad) begin
                            state_q  <= MEASURE;
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                        end else if (vs_fall) begin
                            fs_q <= 1'b1;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign line_period = ref_period_q;
    assign hs_width    = ref_hsw_q;
    assign frame_lines = ref_lines_q;
    assign vs_width    = ref_vsw_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign frame_start = fs_q;

`ifdef VGA_RX_PIXEL_EN
    logic        de_q, de_p_q, pv_q;
    logic [11:0] rgb_q, prgb_q;
    logic [10:0] xcnt_q, px_q;
    logic [9:0]  ycnt_q, py_q;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            de_q   <= 1'b0;
            de_p_q <= 1'b0;
            rgb_q  <= '0;
            xcnt_q <= '0;
            ycnt_q <= '0;
            pv_q   <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            prgb_q <= '0;
        end else begin
            de_q   <= vga_de;
            de_p_q <= de_q;
            rgb_q  <= rgb_in;
            xcnt_q <= de_q ? xcnt_q + 11'd1 : 11'd0;
            if (vs_fall)
                ycnt_q <= '0;
            else if (de_p_q && !de_q)
                ycnt_q <= ycnt_q + 10'd1;
            pv_q   <= de_q & locked_q;
            px_q   <= xcnt_q;
            py_q   <= ycnt_q;
            prgb_q <= rgb_q;
        end
    end

    assign pix_valid = pv_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_rgb   = prgb_q;
`else
    logic unused_pix_in;
    assign unused_pix_in = ^{vga_de, rgb_in};
    assign pix_valid = 1'b0;
    assign pix_x     = '0;
    assign pix_y     = '0;
    assign pix_rgb   = '0;
`endif

endmodule
